// File: rtl/uart_pkg.sv
// uart_pkg: state encoding, parity mode and helpers shared by the UART transmitter and receiver
package uart_pkg;

   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} uart_state_e;

   typedef enum logic {EVEN, ODD} parity_mode_e;

   localparam parity_mode_e PARITY_MODE = EVEN;

   function automatic int CeilLog2(input int v);
      int r = 0;
      while ((1 << r) < v) r++;
      return r;
   endfunction

endpackage

// File: rtl/uart_tx_parity_if.sv
// uart_tx_parity_if: request/serial-line bundle between a frame source and the transmitter
interface uart_tx_parity_if #(parameter int Nbit = 8);

   logic            tx_start;
   logic [Nbit-1:0] tx_data;
   logic            SerialDataOut;
   logic            tx_busy;
   logic            tx_done;

   modport master (output tx_start, tx_data, input SerialDataOut, tx_busy, tx_done);
   modport slave  (input tx_start, tx_data, output SerialDataOut, tx_busy, tx_done);

endinterface

// File: rtl/uart_baud_gen.sv
// uart_baud_gen: free-running bit-period counter, restarted on clear, ticking on the last cycle of each bit
module uart_baud_gen
   import uart_pkg::*;
#(
   parameter int BAUD_DIV = 5208
) (
   input  logic clk,
   input  logic reset,
   input  logic clear,
   output logic tick
);

   localparam int CNT_W = CeilLog2(BAUD_DIV);
   localparam logic [CNT_W-1:0] LAST = CNT_W'(BAUD_DIV - 1);

   logic [CNT_W-1:0] cnt;

   assign tick = cnt == LAST;

   // count 0..BAUD_DIV-1, wrapping at the bit boundary or restarting when a frame is accepted
   always_ff @(posedge clk or posedge reset)
      if (reset)
         cnt <= '0;
      else
         cnt <= (clear || tick) ? '0 : cnt + 1'b1;

endmodule

// File: rtl/uart_tx_parity.sv
// uart_tx_parity: UART transmitter sending start, Nbit data bits LSB first, parity and one stop bit
module uart_tx_parity
   import uart_pkg::*;
#(
   parameter int Nbit      = 8,
   parameter int baudrate  = 9600,
   parameter int clk_freq  = 50000000
) (
   input  logic         clk,
   input  logic         reset,
   uart_tx_parity_if.slave bus
);

   localparam int BAUD_DIV = clk_freq / baudrate;
   localparam int IDX_W    = CeilLog2(Nbit + 1);
   localparam logic [IDX_W-1:0] LAST_BIT = IDX_W'(Nbit - 1);

   uart_state_e     state;
   logic [Nbit-1:0] shreg;
   logic [Nbit-1:0] shnext;
   logic [IDX_W-1:0] bit_idx;
   logic            par;
   logic            line;
   logic            busy;
   logic            done;
   logic            tick;
   logic            accept;

   assign accept = state == IDLE && bus.tx_start;
   assign shnext = shreg >> 1;

   uart_baud_gen #(.BAUD_DIV(BAUD_DIV)) u_baud (
      .clk   (clk),
      .reset (reset),
      .clear (accept),
      .tick  (tick)
   );

   // frame sequencer; the line value is registered together with each state change so it only moves on bit boundaries
   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         state   <= IDLE;
         line    <= 1'b1;
         busy    <= 1'b0;
         done    <= 1'b0;
         bit_idx <= '0;
         shreg   <= '0;
         par     <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               line <= 1'b1;
               busy <= 1'b0;
               if (bus.tx_start) begin
                  shreg <= bus.tx_data;
                  par   <= ^bus.tx_data ^ (PARITY_MODE == ODD);
                  state <= START;
                  line  <= 1'b0;
                  busy  <= 1'b1;
               end
            end
            START:
               if (tick) begin
                  state   <= DATA;
                  bit_idx <= '0;
                  line    <= shreg[0];
               end
            DATA:
               if (tick) begin
                  if (bit_idx == LAST_BIT) begin
                     state <= PARITY;
                     line  <= par;
                  end else begin
                     bit_idx <= bit_idx + 1'b1;
                     shreg   <= shnext;
                     line    <= shnext[0];
                  end
               end
            PARITY:
               if (tick) begin
                  state <= STOP;
                  line  <= 1'b1;
               end
            STOP:
               if (tick) begin
                  state <= IDLE;
                  busy  <= 1'b0;
                  done  <= 1'b1;
               end
            default: state <= IDLE;
         endcase
      end

   assign bus.SerialDataOut = line;
   assign bus.tx_busy       = busy;
   assign bus.tx_done       = done;

endmodule

// File: tb/tb_uart_tx_parity.sv
// tb_uart_tx_parity: randomized self-checking bench against a per-cycle frame model and a sampling receiver
module tb_uart_tx_parity;

   localparam int NB  = 8;
   localparam int DIV = 8;
   localparam int FR  = (NB + 3) * DIV;

   logic clk = 1'b0;
   logic reset = 1'b1;
   int   vectors = 0;
   int   miscompares = 0;

   uart_tx_parity_if #(.Nbit(NB)) bus ();

   uart_tx_parity #(.Nbit(NB), .baudrate(1), .clk_freq(8)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   // expected line level k cycles after accept (1..FR): frame bits start,d0..d7,even parity,stop each DIV cycles wide
   function automatic logic exp_line(input logic [NB-1:0] w, input int k);
      int b = (k - 1) / DIV;
      int ones = 0;
      for (int i = 0; i < NB; i++) ones += int'(w[i]);
      if (b == 0) return 1'b0;
      if (b <= NB) return w[b-1];
      if (b == NB + 1) return (ones % 2) == 1;
      return 1'b1;
   endfunction

   task automatic kick(input logic [NB-1:0] w);
      @(negedge clk);
      bus.tx_start = 1'b1;
      bus.tx_data  = w;
   endtask

   // checks a frame already requested at the previous negedge; optionally injects an ignored request, chains or holds start
   task automatic test_frame(input logic [NB-1:0] w, input int inj, input logic [NB-1:0] inj_d,
                             input bit b2b, input bit hold, input logic [NB-1:0] nxt);
      for (int k = 1; k <= FR + 1; k++) begin
         @(negedge clk);
         vectors++;
         if (k <= FR) begin
            if (bus.SerialDataOut !== exp_line(w, k) || bus.tx_busy !== 1'b1 || bus.tx_done !== 1'b0) begin
               miscompares++;
               $display("FAIL frame %h cycle %0d: line=%b busy=%b done=%b, want line=%b busy=1 done=0",
                        w, k, bus.SerialDataOut, bus.tx_busy, bus.tx_done, exp_line(w, k));
            end
            bus.tx_start = hold || k == inj;
            bus.tx_data  = k == inj ? inj_d : NB'($urandom);
         end else begin
            if (bus.SerialDataOut !== 1'b1 || bus.tx_busy !== 1'b0 || bus.tx_done !== 1'b1) begin
               miscompares++;
               $display("FAIL done %h: line=%b busy=%b done=%b, want line=1 busy=0 done=1",
                        w, bus.SerialDataOut, bus.tx_busy, bus.tx_done);
            end
            bus.tx_start = b2b;
            bus.tx_data  = nxt;
         end
      end
      if (!b2b) begin
         @(negedge clk);
         vectors++;
         if (bus.SerialDataOut !== 1'b1 || bus.tx_busy !== 1'b0 || bus.tx_done !== 1'b0) begin
            miscompares++;
            $display("FAIL after %h: line=%b busy=%b done=%b, want line=1 busy=0 done=0",
                     w, bus.SerialDataOut, bus.tx_busy, bus.tx_done);
         end
      end
   endtask

   task automatic test_reset;
      reset = 1'b1;
      bus.tx_start = 1'b0;
      bus.tx_data  = '0;
      repeat (3) @(negedge clk);
      reset = 1'b0;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         vectors++;
         if (bus.SerialDataOut !== 1'b1 || bus.tx_busy !== 1'b0 || bus.tx_done !== 1'b0) begin
            miscompares++;
            $display("FAIL idle cycle %0d: line=%b busy=%b done=%b, want 1 0 0",
                     i, bus.SerialDataOut, bus.tx_busy, bus.tx_done);
         end
      end
   endtask

   task automatic test_single;
      kick(8'h55);
      test_frame(8'h55, 0, '0, 1'b0, 1'b0, '0);
   endtask

   task automatic test_parity;
      kick(8'h07);
      test_frame(8'h07, 0, '0, 1'b0, 1'b0, '0);
      kick(8'hFF);
      test_frame(8'hFF, 0, '0, 1'b0, 1'b0, '0);
   endtask

   task automatic test_busy_b2b;
      kick(8'h55);
      test_frame(8'h55, 20, 8'hA3, 1'b1, 1'b0, 8'h3C);
      test_frame(8'h3C, 0, '0, 1'b0, 1'b0, '0);
   endtask

   task automatic test_hold;
      logic [NB-1:0] w = NB'($urandom);
      logic [NB-1:0] n;
      kick(w);
      for (int i = 0; i < 3; i++) begin
         n = NB'($urandom);
         test_frame(w, 0, '0, 1'b1, 1'b1, n);
         w = n;
      end
      test_frame(w, 0, '0, 1'b0, 1'b1, '0);
   endtask

   task automatic test_random;
      for (int i = 0; i < 4; i++) begin
         logic [NB-1:0] w = NB'($urandom);
         kick(w);
         test_frame(w, int'($urandom_range(2, FR - 2)), NB'($urandom), 1'b0, 1'b0, '0);
      end
   endtask

   task automatic test_reset_mid;
      kick(8'h0F);
      for (int k = 1; k <= 35; k++) begin
         @(negedge clk);
         vectors++;
         if (bus.SerialDataOut !== exp_line(8'h0F, k)) begin
            miscompares++;
            $display("FAIL pre-reset cycle %0d: line=%b want %b", k, bus.SerialDataOut, exp_line(8'h0F, k));
         end
         bus.tx_start = 1'b0;
      end
      reset = 1'b1;
      #1;
      vectors++;
      if (bus.SerialDataOut !== 1'b1 || bus.tx_busy !== 1'b0 || bus.tx_done !== 1'b0) begin
         miscompares++;
         $display("FAIL async reset: line=%b busy=%b done=%b, want 1 0 0",
                  bus.SerialDataOut, bus.tx_busy, bus.tx_done);
      end
      repeat (2) @(negedge clk);
      reset = 1'b0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         vectors++;
         if (bus.SerialDataOut !== 1'b1 || bus.tx_busy !== 1'b0) begin
            miscompares++;
            $display("FAIL post-reset idle %0d: line=%b busy=%b, want 1 0", i, bus.SerialDataOut, bus.tx_busy);
         end
      end
      kick(8'h81);
      test_frame(8'h81, 0, '0, 1'b0, 1'b0, '0);
   endtask

   // independent mid-bit sampling receiver: recovers the byte and checks even parity and stop bit
   task automatic test_loopback;
      logic [NB-1:0] words [3] = '{8'h00, 8'h5A, 8'hFF};
      for (int j = 0; j < 3; j++) begin
         logic [NB+1:0] rx = '0;
         int wait_cnt = 0;
         kick(words[j]);
         @(negedge clk);
         bus.tx_start = 1'b0;
         while (bus.SerialDataOut !== 1'b0 && wait_cnt < 20) begin
            @(negedge clk);
            wait_cnt++;
         end
         vectors++;
         if (wait_cnt >= 20) begin
            miscompares++;
            $display("FAIL loopback %h: no start bit within 20 cycles", words[j]);
         end else begin
            repeat (DIV / 2) @(negedge clk);
            for (int b = 0; b < NB + 2; b++) begin
               repeat (DIV) @(negedge clk);
               rx[b] = bus.SerialDataOut;
            end
            vectors++;
            if (rx[NB-1:0] !== words[j] || (^rx[NB:0]) !== 1'b0 || rx[NB+1] !== 1'b1) begin
               miscompares++;
               $display("FAIL loopback: got data=%h parity=%b stop=%b, want data=%h even parity stop=1",
                        rx[NB-1:0], rx[NB], rx[NB+1], words[j]);
            end
            repeat (2 * DIV) @(negedge clk);
         end
      end
   endtask

   initial begin
      test_reset;
      test_single;
      test_parity;
      test_busy_b2b;
      test_hold;
      test_random;
      test_reset_mid;
      test_loopback;
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/uart_tx_parity.md
Name: uart_tx_parity

Overview:
- Serial UART transmitter: the transmit end of the MIPS UART link.
- Frames one Nbit word per request: start bit, data LSB first, even parity bit, one stop bit.
- Parity, baud arithmetic and parameter set match the MIPS UART receiver, so a tx→rx loopback with identical parameters must show Parity_error low.
- Sits beside the MIPS data path; the core or bench drives it through a single-cycle start strobe.

Parameters:
- Nbit, 8, number of data bits per frame.
- baudrate, 9600, line bit rate in bits/s.
- clk_freq, 50000000, system clock frequency in Hz.
- BAUD_DIV (localparam), clk_freq/baudrate with integer truncation (5208 at defaults), clock cycles per bit; must be ≥ 2.
- CNT_W (localparam), CeilLog2(BAUD_DIV), width of the baud counter.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-high reset.
- tx_start  input  1  transmit request; sampled only in IDLE.
- tx_data  input  Nbit  word to send; captured in the cycle tx_start is accepted.
- SerialDataOut  output  1  serial line; idles high.
- tx_busy  output  1  high while a frame is on the line.
- tx_done  output  1  one-cycle pulse when a frame completes.

Behaviour:
- Reset (asynchronous, immediate, also mid-frame): state=IDLE, SerialDataOut=1, tx_busy=0, tx_done=0, baud counter=0, bit index=0, shift register=0.
- All outputs are registered.
- FSM states: IDLE, START, DATA, PARITY, STOP.
- IDLE:
  - SerialDataOut=1, tx_busy=0.
  - On tx_start=1: latch tx_data into the shift register, latch parity=^tx_data, go to START.
  - From the next cycle: SerialDataOut=0, tx_busy=1.
  - Latency from tx_start to start-bit edge: 1 cycle.
- Bit timing:
  - Each of START, DATA (per bit), PARITY and STOP holds the line for exactly BAUD_DIV cycles.
  - The baud counter counts 0..BAUD_DIV-1; the state/bit advances when counter=BAUD_DIV-1, with the counter wrapping to 0.
- START: line 0; after BAUD_DIV cycles go to DATA with bit index 0.
- DATA:
  - Line = shift register bit 0 (LSB first); shift right at each bit boundary.
  - After bit index Nbit-1 completes, go to PARITY.
- PARITY:
  - Line = latched even-parity bit (XOR of all data bits), so total ones in data+parity is even.
  - Then go to STOP.
- STOP: line 1; at its last cycle the next state is IDLE.
- Completion:
  - In the first IDLE cycle, tx_done=1 for exactly one cycle and tx_busy=0.
  - Frame length = (Nbit+3)*BAUD_DIV cycles.
- Back-to-back: tx_start high in the tx_done cycle is accepted; the next start bit follows with no extra idle beyond that one cycle.
- tx_start while tx_busy=1: ignored. tx_data changes while busy: no effect on the frame in flight.
- tx_start held high continuously: frames repeat, each re-sampling tx_data in its accept cycle.
- No glitches on SerialDataOut between bit boundaries.

Decomposition:
- Shared package uart_pkg:
  - state enum (IDLE, START, DATA, PARITY, STOP), also used by the receiver;
  - CeilLog2 function;
  - parity-mode constant (EVEN).
- One sub-module: uart_baud_gen.
  - Parameterised by BAUD_DIV.
  - Inputs: clk, reset, clear. Output: tick at counter=BAUD_DIV-1.
  - The transmitter clears it on frame accept.

Test Plan (clk_freq=8, baudrate=1 → BAUD_DIV=8; Nbit=8):
- Reset/idle: reset=1 for 3 cycles, then 0 with no tx_start → SerialDataOut=1, tx_busy=0, tx_done=0 for 100 cycles.
- Single frame: tx_data=0x55 with a 1-cycle tx_start → line holds each bit 8 cycles: 0, 1,0,1,0,1,0,1,0, parity 0, stop 1; tx_busy high 88 cycles; tx_done pulses at cycle 89 after accept.
- Odd parity data: tx_data=0x07 → data bits 1,1,1,0,0,0,0,0; parity bit=1. tx_data=0xFF → parity bit=0.
- Busy ignore and back-to-back:
  - tx_start with 0xA3 at cycle 20 of a 0x55 frame → ignored, 0x55 frame unchanged.
  - tx_start with 0x3C in the tx_done cycle → 0x3C start bit begins the next cycle.
- Reset mid-frame: assert reset during the DATA bit 3 of 0x0F → same cycle SerialDataOut=1, tx_busy=0; after release no frame resumes; a new tx_start with 0x81 sends a full correct frame.
- Loopback: SerialDataOut→MIPS receiver at defaults (BAUD_DIV=5208), send 0x00, 0x5A, 0xFF → received bytes match, Parity_error=0.
